// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl
//   UART transmit frame controller. One block holds the serializer, the bit
//   timer, the frame FSM and the output select. A parallel word is taken with
//   a valid/busy handshake and sent as: a start bit, DATA_WIDTH data bits
//   (LSB first), an optional parity bit, then one or two stop bits. Each bit
//   is held for CLKS_PER_BIT clocks. All outputs come straight from flops.
// Ports
//   CLK        : system clock, rising edge
//   RST        : synchronous reset, active-high
//   P_DATA     : parallel word to send
//   Data_Valid : send request, sampled only while idle
//   PAR_EN     : 1 = insert a parity bit
//   PAR_TYP    : 0 = even parity, 1 = odd parity
//   STOP2      : 0 = one stop bit, 1 = two stop bits
//   TX_OUT     : serial line, idle high
//   Busy       : high from the accept edge to the end of the last stop bit
//   Frame_Done : one-cycle pulse in the final cycle of the last stop bit
//   Tx_Sel     : frame section (0 start, 1 stop, 2 data, 3 parity, 4 idle)
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Frame_Done,
  output logic [2:0]            Tx_Sel
);

  localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_WIDTH);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  // Second-to-last timer count; only meaningful when a bit spans 2+ clocks.
  localparam logic [TMR_W-1:0] TMR_PRE  = TMR_W'((CLKS_PER_BIT >= 2) ? (CLKS_PER_BIT - 2) : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  localparam logic [2:0] SEL_START  = 3'd0;
  localparam logic [2:0] SEL_STOP   = 3'd1;
  localparam logic [2:0] SEL_DATA   = 3'd2;
  localparam logic [2:0] SEL_PARITY = 3'd3;
  localparam logic [2:0] SEL_IDLE   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [TMR_W-1:0]      r_timer;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_stop2;
  logic                  r_tx_out;
  logic                  r_busy;
  logic                  r_done;
  logic [2:0]            r_sel;

  logic                  w_bit_end;
  logic [IDX_W-1:0]      w_stop_last;
  logic                  w_done_nx;

  // Parity of a word: even -> XOR of all bits, odd -> its complement.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic odd);
    parity_bit = odd ? ~^data : ^data;
  endfunction

  assign w_bit_end   = (r_timer == TMR_LAST);
  assign w_stop_last = r_stop2 ? IDX_W'(1) : IDX_W'(0);

  // Frame_Done is registered, so it is raised on the edge that enters the
  // final stop-bit cycle. With one clock per bit that edge is the one that
  // enters the last stop bit itself; otherwise it is one count before the end.
  always_comb begin
    w_done_nx = 1'b0;
    if (CLKS_PER_BIT == 1) begin
      case (r_state)
        ST_DATA:   w_done_nx = (r_idx == IDX_LAST) && !r_par_en && !r_stop2;
        ST_PARITY: w_done_nx = !r_stop2;
        ST_STOP:   w_done_nx = (r_idx == IDX_W'(0)) && r_stop2;
        default:   w_done_nx = 1'b0;
      endcase
    end else begin
      w_done_nx = (r_state == ST_STOP) && (r_timer == TMR_PRE) && (r_idx == w_stop_last);
    end
  end

  // Frame FSM, bit timer, shift register and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_timer   <= TMR_W'(0);
      r_idx     <= IDX_W'(0);
      r_shift   <= DATA_WIDTH'(0);
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_stop2   <= 1'b0;
      r_tx_out  <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sel     <= SEL_IDLE;
    end else begin
      r_done <= w_done_nx;
      case (r_state)
        ST_IDLE: begin
          r_timer <= TMR_W'(0);
          r_idx   <= IDX_W'(0);
          if (Data_Valid) begin
            r_shift   <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_bit <= parity_bit(P_DATA, PAR_TYP);
            r_stop2   <= STOP2;
            r_state   <= ST_START;
            r_tx_out  <= 1'b0;
            r_busy    <= 1'b1;
            r_sel     <= SEL_START;
          end else begin
            r_tx_out <= 1'b1;
            r_busy   <= 1'b0;
            r_sel    <= SEL_IDLE;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_timer  <= TMR_W'(0);
            r_idx    <= IDX_W'(0);
            r_state  <= ST_DATA;
            r_tx_out <= r_shift[0];
            r_shift  <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            r_sel    <= SEL_DATA;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_timer <= TMR_W'(0);
            if (r_idx == IDX_LAST) begin
              r_idx <= IDX_W'(0);
              if (r_par_en) begin
                r_state  <= ST_PARITY;
                r_tx_out <= r_par_bit;
                r_sel    <= SEL_PARITY;
              end else begin
                r_state  <= ST_STOP;
                r_tx_out <= 1'b1;
                r_sel    <= SEL_STOP;
              end
            end else begin
              // The shift register already holds the next data bit at bit 0.
              r_idx    <= r_idx + IDX_W'(1);
              r_tx_out <= r_shift[0];
              r_shift  <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            end
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_timer  <= TMR_W'(0);
            r_idx    <= IDX_W'(0);
            r_state  <= ST_STOP;
            r_tx_out <= 1'b1;
            r_sel    <= SEL_STOP;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_STOP: begin
          // r_idx counts stop bits here.
          if (w_bit_end) begin
            r_timer <= TMR_W'(0);
            if (r_idx == w_stop_last) begin
              r_idx    <= IDX_W'(0);
              r_state  <= ST_IDLE;
              r_tx_out <= 1'b1;
              r_busy   <= 1'b0;
              r_sel    <= SEL_IDLE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_timer  <= TMR_W'(0);
          r_idx    <= IDX_W'(0);
          r_tx_out <= 1'b1;
          r_busy   <= 1'b0;
          r_sel    <= SEL_IDLE;
        end
      endcase
    end
  end

  assign TX_OUT     = r_tx_out;
  assign Busy       = r_busy;
  assign Frame_Done = r_done;
  assign Tx_Sel     = r_sel;

endmodule
